// File: rtl/io_tx_bridge.sv
// io_tx_bridge: memory-mapped CPU byte port feeding a FIFO that drains through a serial transmitter
// Ports: clk_in sole clock; rst_in synchronous active-low reset; rdy_in global enable (low freezes all state);
//        mem_a/mem_dout/mem_wr CPU write bus (mem_a[17:16]=2'b11 selects the block, [2:0]=0 data port, [2:0]=4 stop);
//        io_buffer_full back-pressure; tx serial line (idle high); halt sticky stop; overflow sticky dropped-byte flag.
// Define IO_TX_PARITY_EN to append an even-parity bit to every frame (11-bit frames instead of 10).
module io_tx_bridge #(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic        io_buffer_full,
  output logic        tx,
  output logic        halt,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef IO_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
`ifdef IO_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d, halt_req_q, halt_req_d, halt_q, halt_d, ovf_q, ovf_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic          io_sel, port_wr, stop_wr, full, push, pop, last_cyc, unused_addr;
  assign io_sel         = rdy_in && mem_wr && mem_a[17:16] == 2'b11;
  assign port_wr        = io_sel && mem_a[2:0] == 3'b000 && !halt_req_q && mem_dout != 8'h00;
  assign stop_wr        = io_sel && mem_a[2:0] == 3'b100;
  assign full           = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign push           = port_wr && !full;
  assign pop            = state_q == IDLE && cnt_q != '0;
  assign last_cyc       = cyc_q == CW'(CLKS_PER_BIT - 1);
  assign unused_addr    = ^{mem_a[31:18], mem_a[15:3]};
  // Two slots of slack: the CPU decides on a write one cycle before it lands.
  assign io_buffer_full = cnt_q >= (AW+1)'(FIFO_DEPTH - 2);
  assign halt           = halt_q;
  assign overflow       = ovf_q;
  assign wp_d           = wp_q + AW'(push);
  assign rp_d           = rp_q + AW'(pop);
  assign cnt_d          = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign halt_req_d     = halt_req_q || stop_wr;
  // Halt only once everything already accepted has left the line.
  assign halt_d         = halt_q || (halt_req_q && cnt_q == '0 && state_q == IDLE);
  assign ovf_d          = ovf_q || (port_wr && full);
  always_comb begin
    state_d = state_q;
    cyc_d   = last_cyc ? '0 : cyc_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx      = 1'b1;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (pop) begin
          sh_d    = fifo_q[rp_q];
          par_d   = ^fifo_q[rp_q];
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (last_cyc) state_d = DATA;
      end
      DATA: begin
        tx = sh_q[0];
        if (last_cyc) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = AFTER_DATA;
        end
      end
`ifdef IO_TX_PARITY_EN
      PARITY: begin
        tx = par_q;
        if (last_cyc) state_d = STOP;
      end
`endif
      STOP: if (last_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      cyc_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      halt_req_q <= 1'b0;
      halt_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      halt_req_q <= halt_req_d;
      halt_q     <= halt_d;
      ovf_q      <= ovf_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in && push) fifo_q[wp_q] <= mem_dout;
  end
endmodule

// File: doc/io_tx_bridge.md
IO_TX_BRIDGE -- requirements
Module: io_tx_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output byte FIFO entries; power of two, at least 4.
REQ-002 Parameter CLKS_PER_BIT, default 4, clk_in cycles per serial bit; at least 1.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-low.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 mem_a  input  32  CPU address bus; only bits 17:0 decoded.
REQ-007 mem_dout  input  8  CPU write-data byte.
REQ-008 mem_wr  input  1  CPU write strobe; 1 = write.
REQ-009 io_buffer_full  output  1  back-pressure to the CPU.
REQ-010 tx  output  1  serial line; idle high.
REQ-011 halt  output  1  program-stop indication, sticky.
REQ-012 overflow  output  1  sticky flag; a byte was dropped.

Function
REQ-013 Port write: mem_wr=1 and rdy_in=1 and mem_a[17:16]=2'b11 and mem_a[2:0]=3'b000, with halt_req clear.
REQ-014 Port write with mem_dout != 0: push mem_dout into FIFO; mem_dout = 0x00: ignore, no state change.
REQ-015 Stop write: mem_wr=1, rdy_in=1, mem_a[17:16]=2'b11, mem_a[2:0]=3'b100; sets internal halt_req; later port writes ignored.
REQ-016 Writes with mem_a[17:16] != 2'b11 ignored entirely.
REQ-017 FIFO: write pointer, read pointer and count registers; pointers wrap modulo FIFO_DEPTH.
REQ-018 Push with count = FIFO_DEPTH: byte dropped, overflow set, count unchanged.
REQ-019 Push and pop in same cycle: count unchanged; both pointers advance.
REQ-020 io_buffer_full = 1 while count >= FIFO_DEPTH-2 (two-slot slack for CPU one-cycle decision lag); combinational from registered count.
REQ-021 TX FSM states IDLE, START, DATA, PARITY (macro-gated), STOP.
REQ-022 IDLE: tx=1; if count>0, pop head byte into shift register, go START in next cycle.
REQ-023 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-024 DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; bit index 0..7, then PARITY or STOP.
REQ-025 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE; back-to-back bytes have no extra idle cycle beyond the one IDLE cycle.
REQ-026 Frame length = (10 or 11) x CLKS_PER_BIT cycles, plus 1 IDLE cycle.
REQ-027 halt rises the cycle after halt_req=1, count=0 and FSM in IDLE; stays high until reset.
REQ-028 rdy_in=0: FSM, bit counter, cycle counter, FIFO, flags hold; tx holds current level; no push.

Reset
REQ-029 rst_in=0 at a clock edge: pointers, count, counters cleared; FSM to IDLE; tx=1; halt=0; overflow=0; halt_req=0; io_buffer_full=0.
REQ-030 Reset mid-frame aborts frame immediately (tx=1 next cycle); FIFO contents discarded.
REQ-031 Reset dominates rdy_in and all write inputs.

Configuration
REQ-032 Macro IO_TX_PARITY_EN defined: PARITY state after DATA, tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles; frame 11 bits.
REQ-033 IO_TX_PARITY_EN undefined: no PARITY state; DATA goes directly to STOP; frame 10 bits.

Verification
REQ-034 CLKS_PER_BIT=4, no parity: write 0x41 to 0x30000 -> tx low 4 cycles, then 1,0,0,0,0,0,1,0 each 4 cycles, high 4 cycles; total 40 cycles after the IDLE cycle.
REQ-035 Write 0x00 to 0x30000 -> count stays 0, tx stays 1 for 100 cycles.
REQ-036 FIFO_DEPTH=8, TX stalled by holding first frame: 9 pushes without pop -> io_buffer_full high from count 6, 9th byte dropped, overflow=1.
REQ-037 Push 0x31,0x32, then write 0x30004 -> both frames sent in order; halt rises 1 cycle after second STOP ends; later write 0x33 ignored.
REQ-038 rdy_in low 10 cycles mid-DATA -> tx level frozen; frame resumes and completes 10 cycles late, bit-exact.
REQ-039 IO_TX_PARITY_EN defined, byte 0x07 -> parity bit 1, frame 44 cycles; reset asserted mid-frame -> tx=1 next cycle, count=0.
